// File: rtl/uart_tx_sequencer.sv
// Byte FIFO feeding a UARTController over its register bus: writes the BRG
// divisor after reset, then polls TXBUSY and writes one queued byte per idle status.
module uart_tx_sequencer #(
    parameter logic [15:0] BRG_DIV     = 16'h0001,
    parameter int          DEPTH       = 8,
    parameter int          HOLD_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       wr_i,
    input  logic [7:0] din_i,
    output logic       full_o,
    output logic       empty_o,
    output logic       cfg_done_o,
    output logic       bus_en_o,
    output logic       bus_we_o,
    output logic [7:0] bus_addr_o,
    output logic [7:0] bus_dout_o,
    input  logic [7:0] bus_din_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {
        CFG_LO, CFG_HI, IDLE, POLL_REQ, POLL_WAIT, POLL_CHK, SEND, HOLD
    } state_t;

    state_t          state_q, state_d;
    logic            run_q;
    logic [3:0]      hold_q;
    logic            cfg_done_q;
    logic            bus_en_q, bus_we_q;
    logic [7:0]      bus_addr_q, bus_dout_q;

    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            full_q, empty_q;
    logic            push, pop;

    // Only the TXBUSY bit matters; the rest of the status byte is don't-care.
    logic            unused_din;
    assign unused_din = ^bus_din_i[7:1];

    assign push  = wr_i & ~full_q;
    assign pop   = (state_q == SEND);
    assign cnt_d = cnt_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk_i) begin
        if (!rst_i && push) mem_q[wr_ptr_q] <= din_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == CW'(DEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

    // run_q holds CFG_LO for the first post-reset edge so its write is visible for a full cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CFG_LO:    state_d = run_q ? CFG_HI : CFG_LO;
            CFG_HI:    state_d = IDLE;
            IDLE:      state_d = empty_q ? IDLE : POLL_REQ;
            POLL_REQ:  state_d = POLL_WAIT;
            POLL_WAIT: state_d = POLL_CHK;
            POLL_CHK:  state_d = bus_din_i[0] ? POLL_REQ : SEND;
            SEND:      state_d = HOLD;
            HOLD:      state_d = (hold_q == 4'd0) ? IDLE : HOLD;
            default:   state_d = CFG_LO;
        endcase
    end

    // Bus outputs are registered from the next state, so they always decode the current state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= CFG_LO;
            run_q      <= 1'b0;
            hold_q     <= 4'd0;
            cfg_done_q <= 1'b0;
            bus_en_q   <= 1'b0;
            bus_we_q   <= 1'b0;
            bus_addr_q <= 8'h00;
            bus_dout_q <= 8'h00;
        end else begin
            run_q      <= 1'b1;
            state_q    <= state_d;
            cfg_done_q <= cfg_done_q | (state_d == IDLE);
            if (state_q == SEND)
                hold_q <= 4'(HOLD_CYCLES - 1);
            else if (state_q == HOLD)
                hold_q <= hold_q - 4'd1;
            bus_en_q   <= 1'b0;
            bus_we_q   <= 1'b0;
            bus_addr_q <= 8'h00;
            bus_dout_q <= 8'h00;
            case (state_d)
                CFG_LO: begin
                    bus_en_q   <= 1'b1;
                    bus_we_q   <= 1'b1;
                    bus_addr_q <= 8'h01;
                    bus_dout_q <= BRG_DIV[7:0];
                end
                CFG_HI: begin
                    bus_en_q   <= 1'b1;
                    bus_we_q   <= 1'b1;
                    bus_addr_q <= 8'h02;
                    bus_dout_q <= BRG_DIV[15:8];
                end
                POLL_REQ: begin
                    bus_en_q   <= 1'b1;
                    bus_addr_q <= 8'h00;
                end
                SEND: begin
                    bus_en_q   <= 1'b1;
                    bus_we_q   <= 1'b1;
                    bus_addr_q <= 8'h03;
                    bus_dout_q <= mem_q[rd_ptr_q];
                end
                default: ;
            endcase
        end
    end

    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign cfg_done_o = cfg_done_q;
    assign bus_en_o   = bus_en_q;
    assign bus_we_o   = bus_we_q;
    assign bus_addr_o = bus_addr_q;
    assign bus_dout_o = bus_dout_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Bench for uart_tx_sequencer: a UARTController status model on the bus and a
// queue-based FIFO reference that predicts which bytes must go out, and in what order.
module tb_uart_tx_sequencer;

    localparam logic [15:0] BRG   = 16'h0001;
    localparam int          DEPTH = 8;
    localparam int          HOLD  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr  = 1'b0;
    logic [7:0] din = 8'h00;
    logic       full, empty, cfg_done, en, we;
    logic [7:0] addr, dout;
    logic [7:0] bus_din = 8'h00;

    int total = 0;
    int bad   = 0;

    uart_tx_sequencer #(.BRG_DIV(BRG), .DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .clk_i(clk), .rst_i(rst), .wr_i(wr), .din_i(din),
        .full_o(full), .empty_o(empty), .cfg_done_o(cfg_done),
        .bus_en_o(en), .bus_we_o(we), .bus_addr_o(addr), .bus_dout_o(dout),
        .bus_din_i(bus_din)
    );

    always #5 clk = ~clk;

    // Status register model: TXBUSY from the active mode, other bits random noise.
    logic busy_stuck = 1'b0;
    logic rand_busy  = 1'b0;
    int   busy_polls = 0;
    int   poll_base  = 0;
    int   rd_cnt     = 0;

    always @(posedge clk) begin
        if (en && !we && addr == 8'h00) begin
            logic b;
            b = busy_stuck || (rand_busy && ($urandom_range(0, 2) == 0)) ||
                ((rd_cnt - poll_base) < busy_polls);
            bus_din <= {8'($urandom) & 8'hFE} | {7'd0, b};
            rd_cnt  = rd_cnt + 1;
        end
    end

    // Reference FIFO: bytes accepted in order while fewer than DEPTH are pending.
    logic [7:0] mdl_q[$];
    logic [7:0] exp_log[$];
    logic [7:0] tx_log[$];
    int         tx_cyc[$];
    int         cyc = 0;

    always @(posedge clk) begin
        logic full_b;
        cyc = cyc + 1;
        if (rst) begin
            mdl_q.delete();
        end else begin
            full_b = (mdl_q.size() == DEPTH);
            if (en && we && addr == 8'h03) begin
                tx_log.push_back(dout);
                tx_cyc.push_back(cyc);
                if (mdl_q.size() > 0) void'(mdl_q.pop_front());
            end
            if (wr && !full_b) begin
                mdl_q.push_back(din);
                exp_log.push_back(din);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; wr = 1'b1; din = 8'h5A;
        repeat (3) @(negedge clk);
        total++;
        if ({en, we, addr, dout} !== 18'd0) begin
            bad++; $display("FAIL reset_bus got=%h want=0", {en, we, addr, dout});
        end
        total++;
        if ({empty, full, cfg_done} !== 3'b100) begin
            bad++; $display("FAIL reset_flags got=%b want=100", {empty, full, cfg_done});
        end
        wr = 1'b0; rst = 1'b0;
        @(negedge clk);
        total++;
        if ({en, we, addr, dout, cfg_done} !== {2'b11, 8'h01, BRG[7:0], 1'b0}) begin
            bad++; $display("FAIL cfg_lo got=%h want=%h", {en, we, addr, dout, cfg_done},
                            {2'b11, 8'h01, BRG[7:0], 1'b0});
        end
        @(negedge clk);
        total++;
        if ({en, we, addr, dout, cfg_done} !== {2'b11, 8'h02, BRG[15:8], 1'b0}) begin
            bad++; $display("FAIL cfg_hi got=%h want=%h", {en, we, addr, dout, cfg_done},
                            {2'b11, 8'h02, BRG[15:8], 1'b0});
        end
        @(negedge clk);
        total++;
        if ({cfg_done, en, empty} !== 3'b101) begin
            bad++; $display("FAIL cfg_done got=%b want=101", {cfg_done, en, empty});
        end
    endtask

    task automatic test_single();
        logic [17:0] want;
        busy_stuck = 0; rand_busy = 0; busy_polls = 0;
        wr = 1'b1; din = 8'h75;
        @(negedge clk);
        wr = 1'b0;
        total++;
        if (empty !== 1'b0) begin bad++; $display("FAIL single_nonempty got=%b want=0", empty); end
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) want = {2'b10, 8'h00, 8'h00};
            else if (k == 4) want = {2'b11, 8'h03, 8'h75};
            else want = 18'd0;
            total++;
            if (k == 1 || k == 4) begin
                if ({en, we, addr, dout} !== want) begin
                    bad++; $display("FAIL single_c%0d got=%h want=%h", k, {en, we, addr, dout}, want);
                end
            end else if (en !== 1'b0) begin
                bad++; $display("FAIL single_idle_c%0d got en=%b want 0", k, en);
            end
            if (k == 5) begin
                total++;
                if (empty !== 1'b1) begin bad++; $display("FAIL single_empty got=%b want=1", empty); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int b = tx_log.size();
        logic [7:0] a0 = 8'($urandom), a1 = 8'($urandom);
        wr = 1'b1; din = a0; @(negedge clk);
        din = a1; @(negedge clk);
        wr = 1'b0;
        for (int t = 0; t < 100 && tx_log.size() < b + 2; t++) @(negedge clk);
        total++;
        if (tx_log.size() != b + 2) begin
            bad++; $display("FAIL b2b_timeout got=%0d want=%0d", tx_log.size() - b, 2);
        end else begin
            total++;
            if ({tx_log[b], tx_log[b+1]} !== {a0, a1}) begin
                bad++; $display("FAIL b2b_data got=%h%h want=%h%h", tx_log[b], tx_log[b+1], a0, a1);
            end
            total++;
            if (tx_cyc[b+1] - tx_cyc[b] != HOLD + 5) begin
                bad++; $display("FAIL b2b_spacing got=%0d want=%0d", tx_cyc[b+1] - tx_cyc[b], HOLD + 5);
            end
        end
    endtask

    task automatic test_busy();
        int b = tx_log.size();
        poll_base = rd_cnt; busy_polls = 5;
        wr = 1'b1; din = 8'h41; @(negedge clk);
        wr = 1'b0;
        for (int t = 0; t < 200 && tx_log.size() == b; t++) @(negedge clk);
        repeat (10) @(negedge clk);
        total++;
        if (tx_log.size() != b + 1) begin
            bad++; $display("FAIL busy_count got=%0d want=1", tx_log.size() - b);
        end else begin
            total++;
            if (tx_log[b] !== 8'h41) begin bad++; $display("FAIL busy_data got=%h want=41", tx_log[b]); end
        end
        total++;
        if (rd_cnt - poll_base != 6) begin
            bad++; $display("FAIL busy_reads got=%0d want=6", rd_cnt - poll_base);
        end
        busy_polls = 0;
    endtask

    task automatic test_full();
        int b = tx_log.size();
        busy_stuck = 1'b1;
        for (int i = 0; i < 9; i++) begin
            wr = 1'b1; din = 8'(i);
            @(negedge clk);
            if (i == 6) begin
                total++;
                if (full !== 1'b0) begin bad++; $display("FAIL full_early got=%b want=0", full); end
            end
            if (i == 7) begin
                total++;
                if (full !== 1'b1) begin bad++; $display("FAIL full_at8 got=%b want=1", full); end
            end
        end
        wr = 1'b0;
        busy_stuck = 1'b0;
        for (int t = 0; t < 400 && tx_log.size() < b + 8; t++) @(negedge clk);
        repeat (30) @(negedge clk);
        total++;
        if (tx_log.size() != b + 8) begin
            bad++; $display("FAIL full_count got=%0d want=8", tx_log.size() - b);
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (tx_log[b+i] !== 8'(i)) begin
                    bad++; $display("FAIL full_order[%0d] got=%h want=%h", i, tx_log[b+i], 8'(i));
                end
            end
        end
    endtask

    task automatic test_push_at_pop();
        int  b = tx_log.size();
        bit  seen = 0;
        logic [7:0] want;
        busy_stuck = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr = 1'b1; din = 8'h10 + 8'(i); @(negedge clk);
        end
        din = 8'hAA;
        busy_stuck = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (!full) begin seen = 1; break; end
        end
        total++;
        if (!seen) begin bad++; $display("FAIL pap_timeout got full=%b want 0", full); end
        din = 8'hBB; @(negedge clk);
        wr = 1'b0;
        total++;
        if (full !== 1'b1) begin bad++; $display("FAIL pap_count got full=%b want 1 (count DEPTH-1 after pop)", full); end
        for (int t = 0; t < 400 && tx_log.size() < b + 9; t++) @(negedge clk);
        repeat (20) @(negedge clk);
        total++;
        if (tx_log.size() != b + 9) begin
            bad++; $display("FAIL pap_len got=%0d want=9", tx_log.size() - b);
        end else begin
            for (int i = 0; i < 9; i++) begin
                want = (i < 8) ? 8'h10 + 8'(i) : 8'hBB;
                total++;
                if (tx_log[b+i] !== want) begin
                    bad++; $display("FAIL pap_order[%0d] got=%h want=%h", i, tx_log[b+i], want);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int b;
        bit seen = 0;
        busy_stuck = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr = 1'b1; din = 8'($urandom); @(negedge clk);
        end
        wr = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (en && !we) begin seen = 1; break; end
        end
        total++;
        if (!seen) begin bad++; $display("FAIL mid_no_poll got en=%b we=%b want 1/0", en, we); end
        @(negedge clk);
        rst = 1'b1; wr = 1'b1; din = 8'h99;
        @(negedge clk);
        total++;
        if ({empty, full, cfg_done, en} !== 4'b1000) begin
            bad++; $display("FAIL mid_reset_flags got=%b want=1000", {empty, full, cfg_done, en});
        end
        @(negedge clk);
        rst = 1'b0; wr = 1'b0; busy_stuck = 1'b0;
        b = tx_log.size();
        @(negedge clk);
        total++;
        if ({en, we, addr, dout} !== {2'b11, 8'h01, BRG[7:0]}) begin
            bad++; $display("FAIL mid_cfg_lo got=%h want=%h", {en, we, addr, dout}, {2'b11, 8'h01, BRG[7:0]});
        end
        @(negedge clk);
        total++;
        if ({en, we, addr, dout} !== {2'b11, 8'h02, BRG[15:8]}) begin
            bad++; $display("FAIL mid_cfg_hi got=%h want=%h", {en, we, addr, dout}, {2'b11, 8'h02, BRG[15:8]});
        end
        repeat (60) @(negedge clk);
        total++;
        if (tx_log.size() != b || empty !== 1'b1) begin
            bad++; $display("FAIL mid_flush got sent=%0d empty=%b want 0/1", tx_log.size() - b, empty);
        end
    endtask

    task automatic test_random();
        int bt = tx_log.size();
        int be = exp_log.size();
        rand_busy = 1'b1;
        for (int t = 0; t < 400; t++) begin
            wr = ($urandom_range(0, 3) == 0); din = 8'($urandom);
            @(negedge clk);
            total++;
            if (full !== (mdl_q.size() == DEPTH) || empty !== (mdl_q.size() == 0)) begin
                bad++; $display("FAIL rand_flags t=%0d got full=%b empty=%b want pending=%0d",
                                t, full, empty, mdl_q.size());
            end
        end
        wr = 1'b0; rand_busy = 1'b0;
        for (int t = 0; t < 600 && mdl_q.size() > 0; t++) @(negedge clk);
        repeat (10) @(negedge clk);
        total++;
        if (tx_log.size() - bt != exp_log.size() - be) begin
            bad++; $display("FAIL rand_len got=%0d want=%0d", tx_log.size() - bt, exp_log.size() - be);
        end else begin
            for (int i = 0; i < tx_log.size() - bt; i++) begin
                total++;
                if (tx_log[bt+i] !== exp_log[be+i]) begin
                    bad++; $display("FAIL rand_data[%0d] got=%h want=%h", i, tx_log[bt+i], exp_log[be+i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_busy();
        test_full();
        test_push_at_pop();
        test_reset_mid();
        do_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
